ov7670_cfg_sequencer: RTL and testbench
=======================================

Name: ov7670_cfg_sequencer

Overview:
- Walks the OV7670 register ROM (7-bit address, 16-bit entries: {reg_addr[15:8], value[7:0]}) and issues one SCCB write per entry to the SCCB master.
- Interprets in-table delay and end markers and enforces post-soft-reset settling.
- Reports done/error to the camera top level; restartable so the sensor can be reconfigured without FPGA reset.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency; sets the 1 ms tick divider (CLK_FREQ_HZ/1000 cycles).
- NUM_ENTRIES, 75, ROM entries walked (addresses 0..NUM_ENTRIES-1); must be ≤128.
- RESET_WAIT_MS, 10, mandatory wait after any write of reg 0x12 with bit7=1.
- MAX_RETRY, 3, re-issues of a NACKed write before error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins sequence from address 0
- rom_addr  output  7  ROM address
- rom_data  input  16  ROM entry; combinational read, valid same cycle as rom_addr
- cmd_valid  output  1  write request to SCCB master
- cmd_ready  input  1  SCCB master accepts request when cmd_valid&&cmd_ready
- cmd_reg  output  8  register address
- cmd_wdata  output  8  register value
- cmd_done  input  1  one-cycle pulse: transaction finished
- cmd_nack  input  1  qualified by cmd_done; 1 = slave NACK
- busy  output  1  sequence in progress
- done  output  1  sticky: sequence completed OK; cleared by start/reset
- error  output  1  sticky: retries exhausted; cleared by start/reset

Behaviour:
- Reset values: rom_addr=0, cmd_valid=0, cmd_reg=0, cmd_wdata=0, busy=0, done=0, error=0; state IDLE; counters 0.
- States: IDLE, FETCH, ISSUE, WAIT_ACK, DELAY, FINISH, FAIL.
- IDLE: on start → FETCH, addr=0, clear done/error, busy=1. start is ignored in any other state except FINISH/FAIL (which behave as IDLE).
- FETCH: register rom_data. Decode:
  - 16'hFFFF or addr==NUM_ENTRIES → FINISH.
  - rom_data[15:8]==8'hFF → DELAY for rom_data[7:0] ms; 0 ms means skip to the next entry.
  - Otherwise latch cmd_reg/cmd_wdata, retry_cnt=0 → ISSUE.
- ISSUE: cmd_valid=1; hold cmd_valid/cmd_reg/cmd_wdata stable until cmd_ready; on handshake deassert cmd_valid next cycle → WAIT_ACK.
- WAIT_ACK: on cmd_done with !cmd_nack:
  - if cmd_reg==8'h12 and cmd_wdata[7] → DELAY RESET_WAIT_MS.
  - else addr+1 → FETCH.
- WAIT_ACK, cmd_done with cmd_nack:
  - retry_cnt<MAX_RETRY → retry_cnt+1, ISSUE (same entry).
  - else → FAIL.
- DELAY: ms counter loaded with N; the 1 ms prescaler is restarted on entry; decrements per tick; at 0 → addr+1, FETCH. Duration is N×(CLK_FREQ_HZ/1000) cycles, ±1 cycle.
- FINISH: done=1, busy=0. FAIL: error=1, busy=0, rom_addr frozen at the failing entry for debug.
- Latency: FETCH→cmd_valid is 1 cycle. Per-entry overhead excluding the SCCB transaction is ≤3 cycles.
- Address wrap: never; addr saturates at NUM_ENTRIES.
- cmd_done outside WAIT_ACK is ignored.
- reset mid-operation: cmd_valid drops on the next edge and the state returns to IDLE. Sequencing does not resume automatically; it restarts only on a new start pulse.

Optional Feature:
- CFG_SEQ_AUTOSTART_EN defined: an internal one-shot fires start once, 1 cycle after reset deasserts, so the sensor configures without a top-level pulse. The start port remains functional.
- Undefined: sequencing begins only on the start port.

Decomposition:
- Package ov7670_cfg_pkg: state enum; constants CFG_END_MARKER=16'hFFFF, CFG_DELAY_TAG=8'hFF, REG_COM7=8'h12, COM7_RESET_BIT=7; typedef cfg_entry_t packed {reg, val}.
- One sub-module: ms_delay_timer (prescaler + ms down-counter, load/busy/expire), reused elsewhere for sensor power-up timing.

Test Plan:
- CLK_FREQ_HZ=1000 (tick=1 cycle), 4-entry ROM {1280,FF05,1214,FFFF}, always-ready/ACK master → writes (12,80), then RESET_WAIT_MS wait, then 5-tick delay, then (12,14); done=1 after the end marker; exactly 2 cmd handshakes.
- cmd_ready held low 20 cycles → cmd_valid/cmd_reg/cmd_wdata stable throughout; exactly one handshake.
- NACK on entry 3 twice then ACK → 3 issues of the same entry; sequence completes with done=1, error=0.
- NACK 4 times (MAX_RETRY=3) → error=1, busy=0, rom_addr=3, no further cmd_valid.
- reset asserted during a DELAY of 240 ms → all outputs at reset values next cycle; a later start reruns from addr 0.
- NUM_ENTRIES=75 with no end marker → exactly 75 entries processed (delay entries counted, no write issued for them), then done; rom_addr never exceeds 75.

Source files
------------

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer and its delay timer.
package ov7670_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_DELAY,
      ST_FINISH,
      ST_FAIL
   } cfg_state_t;

   localparam logic [15:0] CFG_END_MARKER = 16'hFFFF;
   localparam logic [7:0]  CFG_DELAY_TAG  = 8'hFF;
   localparam logic [7:0]  REG_COM7       = 8'h12;
   localparam int          COM7_RESET_BIT = 7;
   localparam int          MS_W           = 16;

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] value;
   } cfg_entry_t;

   // A COM7 write with the reset bit set soft-resets the sensor and needs settling time.
   function automatic logic is_com7_reset(input logic [7:0] r, input logic [7:0] v);
      return (r == REG_COM7) && v[COM7_RESET_BIT];
   endfunction

endpackage

// File: rtl/ms_delay_timer.sv
// Millisecond delay timer: a 1 ms prescaler feeding a down-counter of ms.
// load restarts the prescaler; expire is high during the final cycle of the delay.
module ms_delay_timer #(
   parameter int TICK_CYCLES = 100_000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] ms,
   output logic             busy,
   output logic             expire
);

   localparam int             PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt;
   logic             tick;

   assign tick   = busy && (pre == PRE_LAST);
   assign expire = tick && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         pre  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (load) begin
         pre  <= '0;
         cnt  <= ms;
         busy <= (ms != '0);
      end else if (busy) begin
         if (tick) begin
            pre <= '0;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) busy <= 1'b0;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-ROM walker: one SCCB write per entry, in-table delays, COM7 soft-reset settling.
// Define CFG_SEQ_AUTOSTART_EN to fire one internal start the cycle after reset releases.
module ov7670_cfg_sequencer
   import ov7670_cfg_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 100_000_000,
   parameter int NUM_ENTRIES   = 75,
   parameter int RESET_WAIT_MS = 10,
   parameter int MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [6:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_reg,
   output logic [7:0]  cmd_wdata,
   input  logic        cmd_done,
   input  logic        cmd_nack,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int         RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [7:0] LAST_ADDR = 8'(NUM_ENTRIES);

   cfg_state_t       state;
   cfg_entry_t       entry;
   logic [7:0]       addr;  // one bit wider than rom_addr so it can rest at NUM_ENTRIES=128
   logic [RETRY_W-1:0] retry_cnt;
   logic             tmr_load;
   logic [MS_W-1:0]  tmr_ms;
   logic             tmr_busy;
   logic             tmr_expire;
   logic             start_eff;

   assign entry    = cfg_entry_t'(rom_data);
   assign rom_addr = addr[7] ? 7'h7F : addr[6:0];

`ifdef CFG_SEQ_AUTOSTART_EN
   logic auto_armed;

   always_ff @(posedge clk) begin
      if (reset) auto_armed <= 1'b1;
      else       auto_armed <= 1'b0;
   end

   assign start_eff = start | auto_armed;
`else
   assign start_eff = start;
`endif

   ms_delay_timer #(
      .TICK_CYCLES (CLK_FREQ_HZ / 1000),
      .CNT_W       (MS_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .ms     (tmr_ms),
      .busy   (tmr_busy),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr      <= '0;
         retry_cnt <= '0;
         cmd_valid <= 1'b0;
         cmd_reg   <= '0;
         cmd_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         tmr_load  <= 1'b0;
         tmr_ms    <= '0;
      end else begin
         tmr_load <= 1'b0;
         case (state)
            ST_IDLE, ST_FINISH, ST_FAIL: begin
               if (start_eff) begin
                  state <= ST_FETCH;
                  addr  <= '0;
                  done  <= 1'b0;
                  error <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (addr >= LAST_ADDR || rom_data == CFG_END_MARKER) begin
                  state <= ST_FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (entry.reg_addr == CFG_DELAY_TAG) begin
                  if (entry.value == 8'd0) begin
                     addr <= addr + 8'd1;
                  end else begin
                     tmr_ms   <= MS_W'(entry.value);
                     tmr_load <= 1'b1;
                     state    <= ST_DELAY;
                  end
               end else begin
                  cmd_reg   <= entry.reg_addr;
                  cmd_wdata <= entry.value;
                  retry_cnt <= '0;
                  cmd_valid <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (cmd_done) begin
                  if (!cmd_nack) begin
                     if (is_com7_reset(cmd_reg, cmd_wdata)) begin
                        tmr_ms   <= MS_W'(RESET_WAIT_MS);
                        tmr_load <= 1'b1;
                        state    <= ST_DELAY;
                     end else begin
                        addr  <= addr + 8'd1;
                        state <= ST_FETCH;
                     end
                  end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     cmd_valid <= 1'b1;
                     state     <= ST_ISSUE;
                  end else begin
                     state <= ST_FAIL;
                     busy  <= 1'b0;
                     error <= 1'b1;
                  end
               end
            end
            ST_DELAY: begin
               // A zero-length load never raises timer busy, so leave once the load has landed.
               if (tmr_expire || (!tmr_busy && !tmr_load)) begin
                  addr  <= addr + 8'd1;
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Randomised scoreboard bench for ov7670_cfg_sequencer with a behavioural ROM-walk model
// and a responsive SCCB master model.
module tb_ov7670_cfg_sequencer;

   localparam int CLK_HZ  = 1000;
   localparam int TICK    = CLK_HZ / 1000;
   localparam int NUM_E   = 75;
   localparam int RST_MS  = 10;
   localparam int MAX_RTY = 3;
   localparam int W       = 40;   // {min_gap[15:0], slack[7:0], reg[7:0], val[7:0]}

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [6:0]  rom_addr;
   logic [15:0] rom_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_reg;
   logic [7:0]  cmd_wdata;
   logic        cmd_done;
   logic        cmd_nack;
   logic        busy;
   logic        done;
   logic        error;

   logic [15:0] rom [0:127];
   assign rom_data = rom[rom_addr];

   ov7670_cfg_sequencer #(
      .CLK_FREQ_HZ   (CLK_HZ),
      .NUM_ENTRIES   (NUM_E),
      .RESET_WAIT_MS (RST_MS),
      .MAX_RETRY     (MAX_RTY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_reg   (cmd_reg),
      .cmd_wdata (cmd_wdata),
      .cmd_done  (cmd_done),
      .cmd_nack  (cmd_nack),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int          errors = 0;
   int          checks = 0;
   logic [W-1:0] exp_q[$];
   int          anchor = 0;
   int          ready_mode = 1;   // 0 random, 1 always ready, 2 stall 20 cycles per issue
   bit          spurious_en = 1'b0;
   int          nack_entry = -1;
   int          nack_left = 0;
   int          hs_count = 0;
   int          max_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: walk the ROM by the table rules and queue every expected write issue.
   task automatic model_run(input int nack_e, input int nack_n,
                            output bit exp_done, output bit exp_err, output int exp_addr);
      int wait_c;
      int ents;
      wait_c   = 0;
      ents     = 0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_addr = 0;
      for (int a = 0; a <= NUM_E; a++) begin
         if (a == NUM_E || rom[a] == 16'hFFFF) begin
            exp_done = 1'b1;
            exp_addr = a;
            return;
         end
         if (rom[a][15:8] == 8'hFF) begin
            wait_c += int'(rom[a][7:0]) * TICK;
            ents++;
         end else begin
            for (int t = 0; t <= MAX_RTY; t++) begin
               exp_q.push_back({16'(wait_c), 8'(2 * ents + 3), rom[a]});
               wait_c = 0;
               ents   = 0;
               if (!(a == nack_e && t < nack_n)) break;
            end
            if (a == nack_e && nack_n > MAX_RTY) begin
               exp_err  = 1'b1;
               exp_addr = a;
               return;
            end
            if (rom[a][15:8] == 8'h12 && rom[a][7]) begin
               wait_c = RST_MS * TICK;
               ents   = 1;
            end
         end
      end
   endtask

   // SCCB master model
   initial begin
      bit         hs;
      bit         pend;
      int         lat;
      int         stall_n;
      logic [6:0] hs_addr;
      logic [6:0] cur_addr;
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      cmd_nack  = 1'b0;
      pend      = 1'b0;
      lat       = 0;
      stall_n   = 0;
      cur_addr  = '0;
      forever begin
         @(negedge clk);
         hs      = cmd_valid && cmd_ready && !reset;
         hs_addr = rom_addr;
         @(posedge clk);
         #1;
         cmd_done = 1'b0;
         cmd_nack = 1'b0;
         if (reset) pend = 1'b0;
         if (hs) begin
            pend     = 1'b1;
            lat      = $urandom_range(0, 3);
            cur_addr = hs_addr;
            stall_n  = 0;
         end else if (pend) begin
            if (lat == 0) begin
               cmd_done = 1'b1;
               pend     = 1'b0;
               anchor   = cyc;
               if (int'(cur_addr) == nack_entry && nack_left > 0) begin
                  cmd_nack = 1'b1;
                  nack_left--;
               end
            end else begin
               lat--;
            end
         end else if (spurious_en && !cmd_valid && $urandom_range(0, 7) == 0) begin
            cmd_done = 1'b1;
            cmd_nack = 1'($urandom_range(0, 1));
         end
         if (cmd_valid) stall_n++;
         case (ready_mode)
            1:       cmd_ready = 1'b1;
            2:       cmd_ready = (stall_n > 20);
            default: cmd_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // monitor / scoreboard
   initial begin
      bit           prev_valid;
      bit           prev_stall;
      bit           issue_bad;
      int           gap;
      logic [W-1:0] e;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      issue_bad  = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            issue_bad  = 1'b0;
         end else begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (cmd_valid && !prev_valid) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_issue: reg=%02h val=%02h at rom_addr=%0d, no write expected",
                           cmd_reg, cmd_wdata, rom_addr);
               end else begin
                  e   = exp_q[0];
                  gap = cyc - anchor;
                  if (gap < int'(e[39:24]) || gap > int'(e[39:24]) + int'(e[23:16])) begin
                     errors++;
                     $display("FAIL issue_timing: write %04h started %0d cycles after trigger, allowed %0d..%0d",
                              e[15:0], gap, int'(e[39:24]), int'(e[39:24]) + int'(e[23:16]));
                  end
               end
            end
            if (cmd_valid && exp_q.size() != 0 && {cmd_reg, cmd_wdata} !== exp_q[0][15:0])
               issue_bad = 1'b1;
            if (prev_stall && !cmd_valid) begin
               checks++;
               errors++;
               $display("FAIL valid_held: cmd_valid dropped to 0 before handshake, required 1");
            end
            if (cmd_valid && cmd_ready) begin
               hs_count++;
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  checks++;
                  if (issue_bad) begin
                     errors++;
                     $display("FAIL issue_data: reg/val %02h%02h, required %04h stable until handshake",
                              cmd_reg, cmd_wdata, e[15:0]);
                  end
               end
               issue_bad = 1'b0;
            end
            prev_valid = cmd_valid;
            prev_stall = cmd_valid && !cmd_ready;
         end
      end
   end

   // driver tasks
   task automatic pulse_start(input bit set_anchor);
      @(posedge clk);
      #1;
      start = 1'b1;
      if (set_anchor) anchor = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      @(negedge clk);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_cmd_valid"}, cmd_valid, 0);
      chk({tag, "_cmd_reg"}, cmd_reg, 0);
      chk({tag, "_cmd_wdata"}, cmd_wdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      int n;
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (cmd_valid) n++;
      end
      chk({tag, "_no_cmd_valid"}, n, 0);
   endtask

   task automatic gen_rom(input int n, input bit end_mark, input int force_write_at);
      int r;
      for (int i = 0; i < 128; i++) begin
         if (i >= n) begin
            rom[i] = end_mark ? 16'hFFFF : 16'h5A5A;
         end else begin
            r = $urandom_range(0, 9);
            if (r == 0)      rom[i] = {8'hFF, 8'($urandom_range(0, 6))};
            else if (r == 1) rom[i] = {8'h12, 8'h80 | 8'($urandom_range(0, 255))};
            else if (r == 2) rom[i] = {8'h12, 8'($urandom_range(0, 127))};
            else             rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
            if (i == force_write_at && rom[i][15:8] == 8'hFF) rom[i] = 16'h3A04;
         end
      end
   endtask

   task automatic run_seq(input string tag, input int nack_e, input int nack_n, input bit mid_start);
      bit ed;
      bit ee;
      int ea;
      int n;
      nack_entry = nack_e;
      nack_left  = nack_n;
      max_addr   = 0;
      model_run(nack_e, nack_n, ed, ee, ea);
      pulse_start(1'b1);
      n = 0;
      while (!(done || error) && n < 20000) begin
         if (mid_start && n == 60 && busy) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: neither done nor error within 20000 cycles", tag);
      end
      @(negedge clk);
      chk({tag, "_done"}, done, ed);
      chk({tag, "_error"}, error, ee);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rom_addr"}, rom_addr, ea);
      chk({tag, "_pending_writes"}, exp_q.size(), 0);
      chk({tag, "_addr_bound"}, max_addr <= NUM_E, 1);
      exp_q.delete();
   endtask

   initial begin
      #4_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals("rst");

      // COM7 reset write, settle, table delay, second write, end marker
      rom[0] = 16'h1280;
      rom[1] = 16'hFF05;
      rom[2] = 16'h1214;
      rom[3] = 16'hFFFF;
      hs_count = 0;
      run_seq("basic", -1, 0, 1'b0);
      chk("basic_handshakes", hs_count, 2);

      // ready withheld for 20 cycles
      ready_mode = 2;
      rom[0] = 16'h3A04;
      rom[1] = 16'hFFFF;
      hs_count = 0;
      run_seq("stall", -1, 0, 1'b0);
      chk("stall_handshakes", hs_count, 1);
      ready_mode = 0;

      // two NACKs then ACK on entry 3
      gen_rom(6, 1'b1, 3);
      run_seq("nack2", 3, 2, 1'b0);

      // retries exhausted on entry 3
      gen_rom(6, 1'b1, 3);
      run_seq("nack4", 3, 4, 1'b0);
      quiet_window("after_fail", 30);

      // reset in the middle of a 240 ms delay
      rom[0] = 16'h3A04;
      rom[1] = 16'hFFF0;
      rom[2] = 16'h1234;
      rom[3] = 16'hFFFF;
      nack_entry = -1;
      exp_q.push_back({16'd0, 8'd3, 16'h3A04});
      pulse_start(1'b1);
      repeat (50) @(posedge clk);
      #1;
      chk("delay_busy", busy, 1);
      chk("delay_first_write_done", exp_q.size(), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals("mid_reset");
      quiet_window("post_reset", 30);
      gen_rom(8, 1'b1, -1);
      run_seq("rerun", -1, 0, 1'b0);

      // full table without end marker, random ready, stray done pulses, ignored start
      spurious_en = 1'b1;
      gen_rom(NUM_E, 1'b0, -1);
      run_seq("full", -1, 0, 1'b1);
      spurious_en = 1'b0;

      for (int k = 0; k < 4; k++) begin
         int ne;
         ne = $urandom_range(0, 2);
         gen_rom($urandom_range(3, 12), 1'b1, ne);
         run_seq("rnd", ne, $urandom_range(0, 2), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
